// File: rtl/bus_if_ext.sv
// bus_if_ext: memory-stage bus interface steering CPU accesses to the scratch-pad memory or an external shared bus.
// Latency: SPM accesses are combinational (0 cycles); external accesses take at least 3 cycles (req/grant/ready).
// Backpressure: busy stalls the pipeline while an external access is outstanding; read data is held across stalls.
// Optional feature: define BUS_IF_TIMEOUT_EN to abort external accesses that never see bus_rdy_.
module bus_if_ext #(
  parameter int                   ADDR_W    = 30,
  parameter int                   DATA_W    = 32,
  parameter int                   SPM_TAG_W = 3,
  parameter logic [SPM_TAG_W-1:0] SPM_TAG   = 3'b000,
  parameter int                   TMO_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr,
  input  logic              as_,
  input  logic              rw,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              bus_err,
  input  logic [DATA_W-1:0] spm_rd_data,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  // Bus-level encodings: strobes are active low, rw high means read.
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // The timeout counter needs at least one bit even when the feature is compiled out.
  if (TMO_W < 1) begin : g_tmo_w_chk
    $error("bus_if_ext: TMO_W must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACCESS,
    ST_HOLD
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] hold_data;
  logic              spm_sel;
  logic              acc_req;
  logic              spm_hit;
  logic              ext_hit;
  logic              grnt;
  logic              rdy;
  logic              tmo;
  logic              latch;
  logic              grant_acc;
  logic              done;

  // Address decode: the top SPM_TAG_W address bits pick the target.
  assign spm_sel = (addr[ADDR_W-1 -: SPM_TAG_W] == SPM_TAG);
  assign acc_req = (state == ST_IDLE) && !flush && !stall && (as_ == ENABLE_);
  assign spm_hit = acc_req && spm_sel;
  assign ext_hit = acc_req && !spm_sel;
  assign grnt    = (bus_grnt_ == ENABLE_);
  assign rdy     = (bus_rdy_ == ENABLE_);

  // SPM side is a straight pass-through; only the strobe is qualified.
  assign spm_addr    = addr;
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;
  assign spm_as_     = spm_hit ? ENABLE_ : DISABLE_;

`ifdef BUS_IF_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;

  // Count ACCESS cycles; restart whenever a grant moves us into ACCESS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (grant_acc) begin
      tmo_cnt <= '0;
    end else if (state == ST_ACCESS) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo = (state == ST_ACCESS) && !rdy && (&tmo_cnt);
`else
  assign tmo = 1'b0;
`endif

  assign bus_err = tmo;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, busy and read-data steering.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    rd_data   = '0;
    latch     = 1'b0;
    grant_acc = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (spm_hit && (rw == READ)) begin
          rd_data = spm_rd_data;
        end
        if (ext_hit) begin
          busy      = 1'b1;
          latch     = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // Ready is deliberately ignored here; it only counts once in ACCESS.
        busy = 1'b1;
        if (grnt) begin
          grant_acc = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Flush is ignored: once granted, the bus transaction must finish.
        if (rdy) begin
          done = 1'b1;
          if (bus_rw == READ) begin
            rd_data = bus_rd_data;
          end
          state_nxt = stall ? ST_HOLD : ST_IDLE;
        end else if (tmo) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      ST_HOLD: begin
        // Data stays visible on the cycle stall drops, so the stage can consume it.
        if (flush) begin
          state_nxt = ST_IDLE;
        end else begin
          rd_data = hold_data;
          if (!stall) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bus request: raised when the access is latched, dropped after ready or timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_req_ <= DISABLE_;
    end else if (latch) begin
      bus_req_ <= ENABLE_;
    end else if (done) begin
      bus_req_ <= DISABLE_;
    end
  end

  // Bus strobe: a single registered pulse in the first ACCESS cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_as_ <= DISABLE_;
    end else begin
      bus_as_ <= grant_acc ? ENABLE_ : DISABLE_;
    end
  end

  // Bus address/control/data: captured at the hit, stable until back in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_addr    <= '0;
      bus_rw      <= READ;
      bus_wr_data <= '0;
    end else if (latch) begin
      bus_addr    <= addr;
      bus_rw      <= rw;
      bus_wr_data <= wr_data;
    end
  end

  // Hold register: keeps completed read data for the stalled pipeline; writes hold zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data <= '0;
    end else if ((state == ST_ACCESS) && rdy) begin
      hold_data <= (bus_rw == READ) ? bus_rd_data : '0;
    end
  end

endmodule
